// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit -- hardwired Moore control sequencer for a 32-bit accumulator-
// less bus CPU. Steps RESET, T0..T7, HALT; every strobe is a decode of the
// registered step and the opcode latched on entry to T3 (branch T6 also looks
// at CON_FF to decide whether the new PC is loaded).
//
// Ports
//   Clock, Clear         : clock, synchronous active-high reset
//   IR[31:0]             : instruction register, opcode in IR[31:28]
//   CON_FF               : branch condition from the datapath
//   Stop                 : halt request, looked at in T0 only
//   MemReady             : memory handshake (only with CU_MEM_WAIT_EN)
//   PCout..BAout         : bus drivers (at most one high per step)
//   MARin..CONin         : register load enables
//   Gra Grb Grc Rin Rout : register-file select / strobe
//   IncPC Read Write ADD AND OR : misc controls
//   Run                  : high while sequencing (low in RESET and HALT)
//
// Optional feature: define CU_MEM_WAIT_EN to stretch any step asserting Read
// or Write until MemReady=1. Undefined, MemReady is ignored.
// -----------------------------------------------------------------------------
module control_unit (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  input  logic        MemReady,
  output logic        PCout, Zlowout, Zhighout, MDRout, HIout, LOout,
  output logic        InPortout, Cout, BAout,
  output logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
  output logic        OutPortin, CONin,
  output logic        Gra, Grb, Grc, Rin, Rout,
  output logic        IncPC, Read, Write, ADD, AND, OR, Run
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_LD   = 4'h0, OP_LDI  = 4'h1, OP_ST   = 4'h2, OP_ADDI = 4'h3,
    OP_ANDI = 4'h4, OP_ORI  = 4'h5, OP_BRZR = 4'h6, OP_BRNZ = 4'h7,
    OP_BRPL = 4'h8, OP_BRMI = 4'h9, OP_JR   = 4'hA, OP_JAL  = 4'hB,
    OP_MFHI = 4'hC, OP_MFLO = 4'hD, OP_IN   = 4'hE, OP_OUT  = 4'hF
  } op_t;

  state_t state, state_next;
  op_t    op;
  logic   last_step;

`ifdef CU_MEM_WAIT_EN
  logic unused_bits;
  assign unused_bits = ^IR[27:0];
`else
  logic unused_bits;
  assign unused_bits = ^{IR[27:0], MemReady};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state <= S_RESET;
      op    <= OP_LD;
    end else begin
      state <= state_next;
      // T2 never stretches, so leaving T2 is exactly the T3 entry edge.
      if (state == S_T2) op <= op_t'(IR[31:28]);
    end
  end

  // Final execute step of each instruction class.
  always_comb begin
    last_step = 1'b0;
    case (op)
      OP_LD, OP_ST:                          last_step = (state == S_T7);
      OP_LDI, OP_ADDI, OP_ANDI, OP_ORI:      last_step = (state == S_T5);
      OP_BRZR, OP_BRNZ, OP_BRPL, OP_BRMI:    last_step = (state == S_T6);
      OP_JAL:                                last_step = (state == S_T4);
      default:                               last_step = (state == S_T3);
    endcase
  end

  always_comb begin
    // NOTE: every output and next state gets a default first; otherwise any
    // path that skips an assignment infers a latch.
    {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin}       = '0;
    {Gra, Grb, Grc, Rin, Rout}                                               = '0;
    {IncPC, Read, Write, ADD, AND, OR}                                       = '0;
    Run        = (state != S_RESET) && (state != S_HALT);
    state_next = state;

    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (op)
          OP_LD, OP_LDI, OP_ST:               begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          OP_ADDI, OP_ANDI, OP_ORI:           begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          OP_BRZR, OP_BRNZ, OP_BRPL, OP_BRMI: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          OP_JAL:  begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
          OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (op)
          OP_LD, OP_LDI, OP_ST, OP_ADDI: begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
          OP_ANDI: begin Cout = 1'b1; AND = 1'b1; Zin = 1'b1; end
          OP_ORI:  begin Cout = 1'b1; OR = 1'b1; Zin = 1'b1; end
          OP_BRZR, OP_BRNZ, OP_BRPL, OP_BRMI: begin PCout = 1'b1; Yin = 1'b1; end
          OP_JAL:  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (op)
          OP_LD, OP_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
          OP_LDI, OP_ADDI, OP_ANDI, OP_ORI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_BRZR, OP_BRNZ, OP_BRPL, OP_BRMI: begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (op)
          OP_LD: begin Read = 1'b1; MDRin = 1'b1; end
          OP_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          // Branch target sits in Z; PC takes it only when the condition holds.
          OP_BRZR, OP_BRNZ, OP_BRPL, OP_BRMI: begin Zlowout = 1'b1; PCin = CON_FF; end
          default: ;
        endcase
      end
      S_T7: begin
        case (op)
          OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_ST:   Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase

    case (state)
      S_RESET: state_next = S_T0;
      S_T0:    state_next = Stop ? S_HALT : S_T1;
      S_T1:    state_next = S_T2;
      S_T2:    state_next = S_T3;
      S_T3, S_T4, S_T5, S_T6, S_T7:
               state_next = last_step ? S_T0 : state_t'(state + 4'd1);
      default: state_next = S_HALT;
    endcase

`ifdef CU_MEM_WAIT_EN
    // Memory steps hold their strobes until the access completes.
    if ((Read || Write) && !MemReady) state_next = state;
`endif
  end

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit -- directed bench for control_unit. A queue-based reference
// model expands each instruction into its per-cycle strobe vectors; a single
// compare process pops one vector per cycle (on the falling edge) and checks
// the packed DUT outputs, plus the at-most-one-bus-driver rule.
// -----------------------------------------------------------------------------
module tb_control_unit;

  typedef logic [30:0] vec_t;

  // Bit positions of the packed output vector.
  localparam vec_t PCOUT  = vec_t'(1) << 30, ZLOW   = vec_t'(1) << 29,
                   ZHIGH  = vec_t'(1) << 28, MDROUT = vec_t'(1) << 27,
                   HIOUT  = vec_t'(1) << 26, LOOUT  = vec_t'(1) << 25,
                   INPORT = vec_t'(1) << 24, COUT   = vec_t'(1) << 23,
                   BAOUT  = vec_t'(1) << 22, MARIN  = vec_t'(1) << 21,
                   ZIN    = vec_t'(1) << 20, PCIN   = vec_t'(1) << 19,
                   MDRIN  = vec_t'(1) << 18, IRIN   = vec_t'(1) << 17,
                   YIN    = vec_t'(1) << 16, HIIN   = vec_t'(1) << 15,
                   LOIN   = vec_t'(1) << 14, OUTPIN = vec_t'(1) << 13,
                   CONIN  = vec_t'(1) << 12, GRA    = vec_t'(1) << 11,
                   GRB    = vec_t'(1) << 10, GRC    = vec_t'(1) << 9,
                   RIN    = vec_t'(1) << 8,  ROUT   = vec_t'(1) << 7,
                   INCPC  = vec_t'(1) << 6,  READ   = vec_t'(1) << 5,
                   WRITE  = vec_t'(1) << 4,  ADD_   = vec_t'(1) << 3,
                   AND_   = vec_t'(1) << 2,  OR_    = vec_t'(1) << 1,
                   RUN    = vec_t'(1);
  localparam vec_t BUS_MASK = vec_t'(9'h1FF) << 22;

  logic        Clock, Clear, CON_FF, Stop, MemReady;
  logic [31:0] IR;
  logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin;
  logic Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write, ADD, AND, OR, Run;
  vec_t dv;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
    .MemReady(MemReady),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .BAout(BAout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin),
    .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .IncPC(IncPC), .Read(Read), .Write(Write), .ADD(ADD), .AND(AND), .OR(OR),
    .Run(Run)
  );

  assign dv = {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout,
               BAout, MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin,
               CONin, Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write, ADD, AND,
               OR, Run};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t exp_q[$];
  vec_t seq_q[$];

  task automatic check(input string name, input vec_t act, input vec_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- reference model: strobes of step t of opcode op ----
  function automatic int last_t(input int op);
    if (op == 0 || op == 2)  return 7;
    if (op <= 5)             return 5;
    if (op <= 9)             return 6;
    if (op == 11)            return 4;
    return 3;
  endfunction

  function automatic vec_t step_vec(input int op, input int t, input bit con);
    vec_t v;
    v = RUN;
    if (t == 0)      v |= PCOUT | MARIN | INCPC | ZIN;
    else if (t == 1) v |= ZLOW | PCIN | READ | MDRIN;
    else if (t == 2) v |= MDROUT | IRIN;
    else if (op <= 2) begin
      if (t == 3)      v |= GRB | BAOUT | YIN;
      else if (t == 4) v |= COUT | ADD_ | ZIN;
      else if (t == 5) v |= (op == 1) ? (ZLOW | GRA | RIN) : (ZLOW | MARIN);
      else if (t == 6) v |= (op == 0) ? (READ | MDRIN) : (GRA | ROUT | MDRIN);
      else             v |= (op == 0) ? (MDROUT | GRA | RIN) : WRITE;
    end else if (op <= 5) begin
      if (t == 3)      v |= GRB | ROUT | YIN;
      else if (t == 4) v |= COUT | ZIN | ((op == 3) ? ADD_ : (op == 4) ? AND_ : OR_);
      else             v |= ZLOW | GRA | RIN;
    end else if (op <= 9) begin
      if (t == 3)      v |= GRA | ROUT | CONIN;
      else if (t == 4) v |= PCOUT | YIN;
      else if (t == 5) v |= COUT | ADD_ | ZIN;
      else             v |= ZLOW | (con ? PCIN : '0);
    end else begin
      case (op)
        10:      v |= GRA | ROUT | PCIN;
        11:      v |= (t == 3) ? (PCOUT | GRB | RIN) : (GRA | ROUT | PCIN);
        12:      v |= HIOUT | GRA | RIN;
        13:      v |= LOOUT | GRA | RIN;
        14:      v |= INPORT | GRA | RIN;
        default: v |= GRA | ROUT | OUTPIN;
      endcase
    end
    return v;
  endfunction

  // Expand one instruction into its cycle-by-cycle vectors (T1 stretched
  // by mr_low cycles only when memory wait states are built in).
  task automatic build_seq(input int op, input bit con, input int mr_low);
    seq_q.delete();
    for (int t = 0; t <= last_t(op); t++) begin
      seq_q.push_back(step_vec(op, t, con));
`ifdef CU_MEM_WAIT_EN
      if (t == 1) for (int k = 0; k < mr_low; k++) seq_q.push_back(step_vec(op, t, con));
`endif
    end
  endtask

  // ---- compare process ----
  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      check("outputs", dv, e);
      check("bus_single_driver", vec_t'($countones(dv & BUS_MASK) > 1), '0);
    end
  end

  // ---- stimulus ----
  task automatic wait_cycle();
    @(posedge Clock);
    #1;
  endtask

  // Called at the start of a T0 cycle. abort_at >= 0 raises Clear in that
  // cycle; stop_noise drives Stop high in every non-T0 cycle.
  task automatic run_instr(input logic [31:0] ir, input bit con, input int mr_low,
                           input int abort_at, input bit stop_noise);
    int n;
    build_seq(int'(ir[31:28]), con, mr_low);
    n = (abort_at >= 0) ? abort_at + 1 : seq_q.size();
    for (int i = 0; i < n; i++) exp_q.push_back(seq_q[i]);
    IR = ir;
    CON_FF = con;
    for (int i = 0; i < n; i++) begin
      MemReady = !(i >= 1 && i <= mr_low);
      Stop     = stop_noise && (i != 0);
      if (i == abort_at) Clear = 1'b1;
      wait_cycle();
    end
    MemReady = 1'b1;
    Stop     = 1'b0;
  endtask

  // Called at the start of a RESET cycle with Clear high: n RESET cycles.
  task automatic drop_clear(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('0);
      if (i == n - 1) Clear = 1'b0;
      wait_cycle();
    end
  endtask

  initial begin
    Clear = 1'b1; Stop = 1'b0; MemReady = 1'b1; CON_FF = 1'b0; IR = '0;

    // Pin the model with hand-computed values.
    build_seq(1, 1'b0, 0); check("model_ldi_len", vec_t'(seq_q.size()), vec_t'(6));
    build_seq(0, 1'b0, 0); check("model_ld_len", vec_t'(seq_q.size()), vec_t'(8));
    build_seq(6, 1'b1, 0); check("model_br_len", vec_t'(seq_q.size()), vec_t'(7));
    check("model_ldi_t5", step_vec(1, 5, 1'b0), 31'h20000901);
    check("model_ld_t6", step_vec(0, 6, 1'b0), 31'h00040021);
    check("model_br_t6_taken", step_vec(6, 6, 1'b1), 31'h20080001);
    check("model_br_t6_not", step_vec(6, 6, 1'b0), 31'h20000001);

    wait_cycle();                       // first edge: RESET
    drop_clear(2);                      // two checked RESET cycles, then T0

    run_instr(32'h1A800005, 1'b0, 0, -1, 1'b0);   // ldi
    run_instr(32'h00000000, 1'b0, 0, -1, 1'b0);   // ld
    run_instr(32'h00000000, 1'b0, 3, -1, 1'b0);   // ld, MemReady low 3 cycles in T1
    run_instr(32'h61000000, 1'b0, 0, -1, 1'b0);   // brzr not taken
    run_instr(32'h61000000, 1'b1, 0, -1, 1'b0);   // brzr taken
    for (int op = 0; op < 16; op++)
      run_instr({op[3:0], 28'h0123456}, op[0], 0, -1, 1'b1);

    // st aborted in T5: Write must never appear.
    run_instr(32'h20000000, 1'b0, 0, 5, 1'b0);
    drop_clear(1);
    // ld aborted while T1 waits on memory.
    run_instr(32'h00000000, 1'b0, 3, 2, 1'b0);
    drop_clear(1);

    // Clear and Stop together in T0: reset wins, sequencing restarts.
    exp_q.push_back(step_vec(0, 0, 1'b0));
    Stop = 1'b1; Clear = 1'b1; MemReady = 1'b0;
    wait_cycle();
    Stop = 1'b0; MemReady = 1'b1;
    drop_clear(1);
    run_instr(32'h3AB00007, 1'b0, 0, -1, 1'b0);   // addi

    // Stop in T0: HALT with everything low until Clear.
    exp_q.push_back(step_vec(0, 0, 1'b0));
    for (int i = 0; i < 5; i++) exp_q.push_back('0);
    Stop = 1'b1;
    wait_cycle();
    for (int i = 0; i < 5; i++) begin
      Stop = i[0];
      wait_cycle();
    end
    check("halt_all_low", dv, '0);
    exp_q.push_back('0);
    Stop = 1'b0; Clear = 1'b1;
    wait_cycle();
    drop_clear(1);
    run_instr(32'hC4000000, 1'b0, 0, -1, 1'b0);   // mfhi after recovery

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
